sd_read_window_gen: RTL and testbench



---
 rtl/sd_read_window_gen_if.sv | 30 +++
 rtl/sd_read_window_gen.sv | 209 ++++++++++++++++++++
 tb/tb_sd_read_window_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_read_window_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | sd_read_window_gen_if                                                 |
// | Snooped SPI bus inputs and read-window control outputs.               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface sd_read_window_gen_if;
    logic       i_Enable;
    logic       i_SCLK;
    logic       i_CS_N;
    logic       i_MOSI_uP;
    logic       i_MISO_SD;
    logic       o_Read_SD_CTRL;
    logic       o_Busy;
    logic       o_Done;
    logic       o_Error;
    logic [1:0] o_Err_Code;

    modport master (
        output i_Enable, i_SCLK, i_CS_N, i_MOSI_uP, i_MISO_SD,
        input  o_Read_SD_CTRL, o_Busy, o_Done, o_Error, o_Err_Code
    );

    modport slave (
        input  i_Enable, i_SCLK, i_CS_N, i_MOSI_uP, i_MISO_SD,
        output o_Read_SD_CTRL, o_Busy, o_Done, o_Error, o_Err_Code
    );
endinterface
`default_nettype wire

// File: rtl/sd_read_window_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | sd_read_window_gen                                                    |
// | Snoops SPI mode-0 traffic and forces SD MOSI high for a CMD17 read.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sd_read_window_gen #(
    parameter int CMD_INDEX      = 17,
    parameter int BLOCK_BYTES    = 512,
    parameter int MAX_WAIT_BYTES = 4096
) (
    input wire                  i_Clk,
    input wire                  i_Rst_N,
    sd_read_window_gen_if.slave bus
);
    localparam int c_WAIT_W = $clog2(MAX_WAIT_BYTES + 1);
    localparam int c_DATA_W = $clog2(BLOCK_BYTES + 3);
    localparam logic [7:0]          c_CMD_BYTE  = 8'h40 | 8'(CMD_INDEX);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(MAX_WAIT_BYTES);
    localparam logic [c_DATA_W-1:0] c_DATA_LAST = c_DATA_W'(BLOCK_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_R1    = 3'd2,
        S_TOKEN = 3'd3,
        S_DATA  = 3'd4
    } state_t;

    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_cs_meta,   r_cs_sync;
    logic r_mosi_meta, r_mosi_sync;
    logic r_miso_meta, r_miso_sync;

    // Only seven history bits are stored; the eighth is the live synchronised sample.
    logic [6:0] r_mosi_sr;
    logic [6:0] r_miso_sr;
    logic [2:0] r_bit_cnt;

    state_t              r_state;
    logic [2:0]          r_cmd_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_DATA_W-1:0] r_data_cnt;
    logic                r_read_ctrl;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [1:0]          r_err_code;

    logic       w_sclk_rise;
    logic       w_byte_done;
    logic [7:0] w_mosi_byte;
    logic [7:0] w_miso_byte;
    logic       w_abort;
    logic [1:0] w_abort_code;

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_sclk_meta <= bus.i_SCLK;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_cs_meta   <= bus.i_CS_N;
            r_cs_sync   <= r_cs_meta;
            r_mosi_meta <= bus.i_MOSI_uP;
            r_mosi_sync <= r_mosi_meta;
            r_miso_meta <= bus.i_MISO_SD;
            r_miso_sync <= r_miso_meta;
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_byte_done = w_sclk_rise & ~r_cs_sync & (r_bit_cnt == 3'd7);
    assign w_mosi_byte = {r_mosi_sr, r_mosi_sync};
    assign w_miso_byte = {r_miso_sr, r_miso_sync};

    // Holding the counter clear while CS is high realigns every new frame to bit 0.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_bit_cnt <= 3'd0;
            r_mosi_sr <= 7'd0;
            r_miso_sr <= 7'd0;
        end else if (r_cs_sync) begin
            r_bit_cnt <= 3'd0;
        end else if (w_sclk_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_mosi_sr <= w_mosi_byte[6:0];
            r_miso_sr <= w_miso_byte[6:0];
        end
    end

    always_comb begin
        w_abort      = 1'b0;
        w_abort_code = 2'b00;
        if (r_state != S_IDLE && r_cs_sync) begin
            w_abort      = 1'b1;
            w_abort_code = 2'b11;
        end else if ((r_state == S_R1 || r_state == S_TOKEN) && r_wait_cnt >= c_WAIT_MAX) begin
            w_abort      = 1'b1;
            w_abort_code = 2'b10;
        end else if (w_byte_done) begin
            if (r_state == S_R1 && !w_miso_byte[7] && w_miso_byte != 8'h00) begin
                w_abort      = 1'b1;
                w_abort_code = 2'b01;
            end
            if (r_state == S_TOKEN && w_miso_byte != 8'hFE && w_miso_byte != 8'hFF) begin
                w_abort      = 1'b1;
                w_abort_code = 2'b01;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_state     <= S_IDLE;
            r_cmd_cnt   <= 3'd0;
            r_wait_cnt  <= '0;
            r_data_cnt  <= '0;
            r_read_ctrl <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_error     <= 1'b1;
                r_err_code  <= w_abort_code;
                r_read_ctrl <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_byte_done && w_mosi_byte == c_CMD_BYTE && bus.i_Enable) begin
                            r_state   <= S_CMD;
                            r_cmd_cnt <= 3'd1;
                            r_busy    <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        if (w_byte_done) begin
                            if (r_cmd_cnt == 3'd5) begin
                                r_state     <= S_R1;
                                r_wait_cnt  <= '0;
                                r_read_ctrl <= 1'b1;
                            end else begin
                                r_cmd_cnt <= r_cmd_cnt + 3'd1;
                            end
                        end
                    end
                    S_R1: begin
                        // A nonzero R1 has already been turned into an abort above.
                        if (w_byte_done && !w_miso_byte[7]) begin
                            r_state    <= S_TOKEN;
                            r_wait_cnt <= '0;
                        end else if (w_byte_done && w_miso_byte == 8'hFF && r_wait_cnt < c_WAIT_MAX) begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    S_TOKEN: begin
                        if (w_byte_done && w_miso_byte == 8'hFE) begin
                            r_state    <= S_DATA;
                            r_data_cnt <= '0;
                        end else if (w_byte_done && r_wait_cnt < c_WAIT_MAX) begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_byte_done) begin
                            if (r_data_cnt == c_DATA_LAST) begin
                                r_state     <= S_IDLE;
                                r_done      <= 1'b1;
                                r_read_ctrl <= 1'b0;
                                r_busy      <= 1'b0;
                            end else begin
                                r_data_cnt <= r_data_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_read_ctrl <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_Read_SD_CTRL = r_read_ctrl;
    assign bus.o_Busy         = r_busy;
    assign bus.o_Done         = r_done;
    assign bus.o_Error        = r_error;
    assign bus.o_Err_Code     = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_sd_read_window_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_sd_read_window_gen                                                 |
// | Directed bench: SPI frames driven at a 10x clock ratio.               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_sd_read_window_gen;
    localparam int BLK = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_vec    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int last_rise = 0;
    int rise_cyc = 0;
    int err_cyc  = 0;
    int n_done   = 0;
    int n_err    = 0;
    int fall_bad = 0;
    int busy_cnt = 0;
    logic prev_rc = 1'b0;

    int d0, e0, b0, t0;

    sd_read_window_gen_if bus();

    sd_read_window_gen #(
        .CMD_INDEX      (17),
        .BLOCK_BYTES    (BLK),
        .MAX_WAIT_BYTES (8)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_N (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_rc <= bus.o_Read_SD_CTRL;
        if (bus.o_Read_SD_CTRL && !prev_rc) rise_cyc <= cyc;
        if (rst_n && !bus.o_Read_SD_CTRL && prev_rc && !(bus.o_Done || bus.o_Error))
            fall_bad <= fall_bad + 1;
        if (bus.o_Done) n_done <= n_done + 1;
        if (bus.o_Error) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
            if (bus.o_Read_SD_CTRL) fall_bad <= fall_bad + 1;
        end
        if (bus.o_Busy || bus.o_Read_SD_CTRL) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] mo, input logic [7:0] mi);
        for (int b = 7; b >= 0; b--) begin
            @(negedge clk);
            bus.i_MOSI_uP = mo[b];
            bus.i_MISO_SD = mi[b];
            repeat (4) @(negedge clk);
            bus.i_SCLK = 1'b1;
            last_rise  = cyc;
            repeat (5) @(negedge clk);
            bus.i_SCLK = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        spi_byte(c, 8'hFF);
        for (int i = 0; i < 4; i++) spi_byte(8'h00, 8'hFF);
        spi_byte(8'h95, 8'hFF);
    endtask

    task automatic cs_gap();
        @(negedge clk);
        bus.i_CS_N = 1'b1;
        repeat (20) @(negedge clk);
        bus.i_CS_N = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        bus.i_Enable  = 1'b0;
        bus.i_SCLK    = 1'b0;
        bus.i_CS_N    = 1'b1;
        bus.i_MOSI_uP = 1'b1;
        bus.i_MISO_SD = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_read_ctrl", int'(bus.o_Read_SD_CTRL), 0);
        chk("rst_busy",      int'(bus.o_Busy), 0);
        chk("rst_done",      int'(bus.o_Done), 0);
        chk("rst_error",     int'(bus.o_Error), 0);
        chk("rst_err_code",  int'(bus.o_Err_Code), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Filtering: CMD24 with enable, then CMD17 with enable low
        b0 = busy_cnt;
        bus.i_Enable = 1'b1;
        bus.i_CS_N   = 1'b0;
        repeat (5) @(negedge clk);
        send_cmd(8'h58);
        spi_byte(8'hFF, 8'h00);
        spi_byte(8'hFF, 8'hFE);
        bus.i_Enable = 1'b0;
        cs_gap();
        send_cmd(8'h51);
        spi_byte(8'hFF, 8'h00);
        spi_byte(8'hFF, 8'hFE);
        repeat (2) @(negedge clk);
        chk("filter_busy_cycles", busy_cnt - b0, 0);
        chk("filter_busy_now",    int'(bus.o_Busy), 0);

        // Normal read
        cs_gap();
        bus.i_Enable = 1'b1;
        d0 = n_done;
        e0 = n_err;
        spi_byte(8'h51 & 8'h40 | 8'h11, 8'hFF);
        chk("cmd_busy_after_byte1", int'(bus.o_Busy), 1);
        chk("cmd_rc_low_in_cmd",    int'(bus.o_Read_SD_CTRL), 0);
        for (int i = 0; i < 4; i++) spi_byte(8'h00, 8'hFF);
        spi_byte(8'h95, 8'hFF);
        chk("cmd_rc_high", int'(bus.o_Read_SD_CTRL), 1);
        chk("cmd_rc_latency_le4", ((rise_cyc - last_rise) >= 1 && (rise_cyc - last_rise) <= 4) ? 1 : 0, 1);
        bus.i_Enable = 1'b0;
        spi_byte(8'hFF, 8'hFF);
        spi_byte(8'hFF, 8'h00);
        for (int i = 0; i < 3; i++) spi_byte(8'hFF, 8'hFF);
        spi_byte(8'hFF, 8'hFE);
        for (int i = 0; i < BLK; i++) spi_byte(8'hFF, 8'(i) ^ 8'hA5);
        spi_byte(8'hFF, 8'h3C);
        chk("read_rc_before_last_crc",   int'(bus.o_Read_SD_CTRL), 1);
        chk("read_no_done_before_crc",   n_done - d0, 0);
        spi_byte(8'hFF, 8'hC3);
        repeat (2) @(negedge clk);
        chk("read_done_once",   n_done - d0, 1);
        chk("read_no_error",    n_err - e0, 0);
        chk("read_rc_released", int'(bus.o_Read_SD_CTRL), 0);
        chk("read_busy_clear",  int'(bus.o_Busy), 0);
        chk("read_rc_fall_with_pulse", fall_bad, 0);

        // Token timeout after the 8th FF
        cs_gap();
        bus.i_Enable = 1'b1;
        e0 = n_err;
        send_cmd(8'h51);
        spi_byte(8'hFF, 8'h00);
        for (int i = 0; i < 7; i++) spi_byte(8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        chk("tmo_no_abort_after_7", n_err - e0, 0);
        chk("tmo_rc_still_high",    int'(bus.o_Read_SD_CTRL), 1);
        spi_byte(8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        chk("tmo_abort_after_8", n_err - e0, 1);
        chk("tmo_err_code",      int'(bus.o_Err_Code), 2);
        chk("tmo_rc_low",        int'(bus.o_Read_SD_CTRL), 0);

        // CS release after 100 data bytes
        cs_gap();
        e0 = n_err;
        send_cmd(8'h51);
        spi_byte(8'hFF, 8'h00);
        spi_byte(8'hFF, 8'hFE);
        for (int i = 0; i < 100; i++) spi_byte(8'hFF, 8'(i));
        @(negedge clk);
        bus.i_CS_N = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (n_err != e0) break;
        end
        chk("cs_abort_once",       n_err - e0, 1);
        chk("cs_abort_latency_le3", ((err_cyc - t0) >= 1 && (err_cyc - t0) <= 3) ? 1 : 0, 1);
        chk("cs_err_code",         int'(bus.o_Err_Code), 3);
        chk("cs_rc_low",           int'(bus.o_Read_SD_CTRL), 0);
        chk("cs_busy_low",         int'(bus.o_Busy), 0);

        // Following CMD17 is handled, then answered with R1 = 05
        repeat (10) @(negedge clk);
        bus.i_CS_N = 1'b0;
        repeat (5) @(negedge clk);
        e0 = n_err;
        send_cmd(8'h51);
        chk("next_cmd_rc_high", int'(bus.o_Read_SD_CTRL), 1);
        chk("next_cmd_busy",    int'(bus.o_Busy), 1);
        spi_byte(8'hFF, 8'hFF);
        spi_byte(8'hFF, 8'h05);
        repeat (2) @(negedge clk);
        chk("r1_abort_once", n_err - e0, 1);
        chk("r1_err_code",   int'(bus.o_Err_Code), 1);
        chk("r1_rc_low",     int'(bus.o_Read_SD_CTRL), 0);
        chk("r1_rc_fall_with_error", fall_bad, 0);

        // Asynchronous reset while waiting for the token
        cs_gap();
        send_cmd(8'h51);
        spi_byte(8'hFF, 8'h00);
        chk("token_rc_high", int'(bus.o_Read_SD_CTRL), 1);
        chk("token_busy",    int'(bus.o_Busy), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rc",       int'(bus.o_Read_SD_CTRL), 0);
        chk("arst_busy",     int'(bus.o_Busy), 0);
        chk("arst_done",     int'(bus.o_Done), 0);
        chk("arst_error",    int'(bus.o_Error), 0);
        chk("arst_err_code", int'(bus.o_Err_Code), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
